// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file slave.
// Holds the transfer FSM states, the word-alignment shift and the strobe-width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int ADDR_ALIGN = 2;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Counts access wait states; done rises once WAIT_STATES cycles have been counted.
module apb_wait_counter #(
  parameter int WAIT_STATES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0] cnt;

  // Saturates at the wait-state count so done stays high until the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(WAIT_STATES));

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave with a DEPTH x DATA_W register file, byte strobes, fixed wait states
// and PSLVERR on bad addresses or an access phase that arrives without a setup phase.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [ADDR_W-1:0]         PRWADDR,
  input  logic [DATA_W-1:0]         PRWDATA,
  input  logic [strb_w(DATA_W)-1:0] PSTRB,
  output logic [DATA_W-1:0]         PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);

  apb_state_e state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] regs [DEPTH];

  logic             cnt_clear, cnt_enable, cnt_done;
  logic             addr_ok, violation, complete, commit;
  logic [IDX_W-1:0] idx;

  apb_wait_counter #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait (
    .clk   (PCLK),
    .rst_n (PRESET),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .done  (cnt_done)
  );

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropping PSEL before completion abandons the transfer without touching the registers.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        cnt_clear  = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        if (cnt_done) begin
          state_next = (PSEL && !PENABLE) ? SETUP : IDLE;
        end else if (!PSEL) begin
          state_next = IDLE;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The transfer uses the setup-phase snapshot, so later bus changes are ignored.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (state == SETUP) begin
      addr_q  <= PRWADDR;
      write_q <= PWRITE;
      wdata_q <= PRWDATA;
      strb_q  <= PSTRB;
    end
  end

  assign idx     = addr_q[IDX_W+ADDR_ALIGN-1:ADDR_ALIGN];
  assign addr_ok = (addr_q[ADDR_ALIGN-1:0] == '0) && (addr_q < ADDR_LIMIT);

  // The violation response comes straight from the bus, so reset must mask it.
  assign violation = PRESET && (state == IDLE) && PSEL && PENABLE;
  assign complete  = (state == ACCESS) && cnt_done;
  assign commit    = complete && addr_ok && write_q && PSEL && PENABLE;

  assign PREADY  = violation || complete;
  assign PSLVERR = violation || (complete && !addr_ok);
  assign PRDATA  = (complete && addr_ok && !write_q) ? regs[idx] : '0;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) begin
          regs[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench: instance A is the default build (WAIT_STATES=2), instance B is
// WAIT_STATES=0 with DEPTH=16 and DATA_W=64; a monitor checks every PREADY against a queue.
module tb_apb_regfile_slave;

  typedef struct packed {
    logic        which;
    logic [63:0] rdata;
    logic        err;
    logic [7:0]  waits;
    logic [15:0] id;
  } exp_t;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        psel_a, psel_b, PENABLE, PWRITE;
  logic [31:0] paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;

  logic [31:0] prdata_a;
  logic        pready_a, pslverr_a;
  logic [63:0] prdata_b;
  logic        pready_b, pslverr_b;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   id_next = 0;
  int   waits_a = 0;
  int   waits_b = 0;

  always #5 PCLK = ~PCLK;

  apb_regfile_slave #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(8), .WAIT_STATES(2)
  ) dut_a (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_a), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRWADDR(paddr), .PRWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
  );

  apb_regfile_slave #(
    .DATA_W(64), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(0)
  ) dut_b (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_b), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRWADDR(paddr), .PRWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
  );

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input logic which, input logic [63:0] rdata, input logic err,
                             input int waits);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_pready dut=%0d got=1 want=0", which);
      return;
    end
    e = sbq.pop_front();
    checkValue($sformatf("txn%0d_dut", e.id), {63'h0, which}, {63'h0, e.which});
    checkValue($sformatf("txn%0d_prdata", e.id), rdata, e.rdata);
    checkValue($sformatf("txn%0d_pslverr", e.id), {63'h0, err}, {63'h0, e.err});
    checkValue($sformatf("txn%0d_waits", e.id), 64'(waits), 64'(e.waits));
  endtask

  // Wait cycles are master access-phase cycles seen with PREADY low.
  initial begin : monitor
    forever begin
      @(negedge PCLK);
      if (pready_a === 1'b1) checkOutput(1'b0, {32'h0, prdata_a}, pslverr_a, waits_a);
      if (pready_b === 1'b1) checkOutput(1'b1, prdata_b, pslverr_b, waits_b);
      if (!psel_a || pready_a) waits_a = 0;
      else if (PENABLE) waits_a = waits_a + 1;
      if (!psel_b || pready_b) waits_b = 0;
      else if (PENABLE) waits_b = waits_b + 1;
    end
  end

  task automatic pushExp(input logic which, input logic [63:0] rdata, input logic err,
                         input int waits);
    exp_t e;
    e.which = which;
    e.rdata = rdata;
    e.err   = err;
    e.waits = 8'(waits);
    e.id    = 16'(id_next);
    id_next++;
    sbq.push_back(e);
  endtask

  task automatic busIdle();
    @(posedge PCLK); #1;
    psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic waitReady(input logic which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if ((which ? pready_b : pready_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL pready_timeout dut=%0d got=0 want=1", which);
    end
  endtask

  task automatic startXfer(input logic which, input logic wr, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [7:0] strb);
    @(posedge PCLK); #1;
    psel_a = !which; psel_b = which; PENABLE = 1'b0;
    PWRITE = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
  endtask

  // keep leaves PSEL high so the next call starts its setup phase straight away.
  task automatic applyStimulus(input logic which, input logic wr, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [7:0] strb,
                               input logic [63:0] exp_rdata, input logic exp_err,
                               input int exp_waits, input bit keep);
    bit ok;
    pushExp(which, exp_rdata, exp_err, exp_waits);
    startXfer(which, wr, addr, wdata, strb);
    waitReady(which, ok);
    if (!keep) busIdle();
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin : stimulus
    bit ok;
    PRESET = 1'b0;
    psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    #12;
    checkValue("rst_pready_a", {63'h0, pready_a}, 64'h0);
    checkValue("rst_pslverr_a", {63'h0, pslverr_a}, 64'h0);
    checkValue("rst_prdata_a", {32'h0, prdata_a}, 64'h0);
    checkValue("rst_pready_b", {63'h0, pready_b}, 64'h0);
    checkValue("rst_prdata_b", prdata_b, 64'h0);
    PRESET = 1'b1;

    // Basic write/read, three wait cycles on instance A.
    applyStimulus(0, 1, 32'h0, 64'h5A5A_5A5A, 8'hF, 64'h0, 0, 3, 0);
    applyStimulus(0, 1, 32'h8, 64'h0000_000F, 8'hF, 64'h0, 0, 3, 0);
    applyStimulus(0, 0, 32'h8, 64'h0, 8'h0, 64'h0000_000F, 0, 3, 0);

    // Byte strobes and an all-zero strobe.
    applyStimulus(0, 1, 32'h4, 64'h1122_3344, 8'hF, 64'h0, 0, 3, 0);
    applyStimulus(0, 1, 32'h4, 64'hAABB_CCDD, 8'h5, 64'h0, 0, 3, 0);
    applyStimulus(0, 0, 32'h4, 64'h0, 8'h0, 64'h11BB_33DD, 0, 3, 0);
    applyStimulus(0, 1, 32'h4, 64'hFFFF_FFFF, 8'h0, 64'h0, 0, 3, 0);
    applyStimulus(0, 0, 32'h4, 64'h0, 8'h0, 64'h11BB_33DD, 0, 3, 0);

    // Out-of-range and misaligned accesses leave the aliased registers alone.
    applyStimulus(0, 0, 32'h20, 64'h0, 8'h0, 64'h0, 1, 3, 0);
    applyStimulus(0, 1, 32'h6, 64'hFFFF_FFFF, 8'hF, 64'h0, 1, 3, 0);
    applyStimulus(0, 1, 32'h20, 64'hFFFF_FFFF, 8'hF, 64'h0, 1, 3, 0);
    applyStimulus(0, 0, 32'h4, 64'h0, 8'h0, 64'h11BB_33DD, 0, 3, 0);
    applyStimulus(0, 0, 32'h0, 64'h0, 8'h0, 64'h5A5A_5A5A, 0, 3, 0);
    applyStimulus(0, 0, 32'h8, 64'h0, 8'h0, 64'h0000_000F, 0, 3, 0);

    // Access phase straight from IDLE.
    pushExp(0, 64'h0, 1, 0);
    @(posedge PCLK); #1;
    psel_a = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
    paddr = 32'h0; pwdata = 64'hFFFF_FFFF; pstrb = 8'hF;
    busIdle();
    applyStimulus(0, 0, 32'h0, 64'h0, 8'h0, 64'h5A5A_5A5A, 0, 3, 0);

    // Back-to-back writes, then read both.
    applyStimulus(0, 1, 32'h10, 64'hCAFE_0001, 8'hF, 64'h0, 0, 3, 1);
    applyStimulus(0, 1, 32'h14, 64'hCAFE_0002, 8'hF, 64'h0, 0, 3, 0);
    applyStimulus(0, 0, 32'h10, 64'h0, 8'h0, 64'hCAFE_0001, 0, 3, 0);
    applyStimulus(0, 0, 32'h14, 64'h0, 8'h0, 64'hCAFE_0002, 0, 3, 0);

    // PSEL dropped mid-access.
    startXfer(0, 1, 32'h1C, 64'hDEAD_BEEF, 8'hF);
    busIdle();
    repeat (2) @(posedge PCLK);
    applyStimulus(0, 0, 32'h1C, 64'h0, 8'h0, 64'h0, 0, 3, 0);

    // Reset asserted on the completion cycle of a read forces outputs low at once.
    pushExp(0, 64'h11BB_33DD, 0, 3);
    startXfer(0, 0, 32'h4, 64'h0, 8'h0);
    waitReady(0, ok);
    #1 PRESET = 1'b0;
    #1;
    checkValue("async_rst_pready", {63'h0, pready_a}, 64'h0);
    checkValue("async_rst_pslverr", {63'h0, pslverr_a}, 64'h0);
    checkValue("async_rst_prdata", {32'h0, prdata_a}, 64'h0);
    psel_a = 1'b0; PENABLE = 1'b0;
    #10 PRESET = 1'b1;
    applyStimulus(0, 0, 32'h0, 64'h0, 8'h0, 64'h0, 0, 3, 0);
    applyStimulus(0, 0, 32'h4, 64'h0, 8'h0, 64'h0, 0, 3, 0);

    // Instance B: zero wait states, 64-bit data, 16 registers.
    applyStimulus(1, 1, 32'h3C, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 0, 1, 0);
    applyStimulus(1, 0, 32'h3C, 64'h0, 8'h0, 64'h0123_4567_89AB_CDEF, 0, 1, 0);
    applyStimulus(1, 1, 32'h3C, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, 0, 1, 0);
    applyStimulus(1, 0, 32'h3C, 64'h0, 8'h0, 64'h0123_4567_FFFF_FFFF, 0, 1, 0);
    applyStimulus(1, 0, 32'h40, 64'h0, 8'h0, 64'h0, 1, 1, 0);
    applyStimulus(1, 1, 32'h40, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1, 1, 0);
    applyStimulus(1, 0, 32'h0, 64'h0, 8'h0, 64'h0, 0, 1, 0);

    repeat (3) @(posedge PCLK);
    checkValue("scoreboard_empty", 64'(sbq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
